// File: rtl/dec_regfile_sb.sv
// Decode-stage register file with write-pending scoreboard and D->E issue register.
// Optional macro RF_BYPASS_EN: forward writeback data into reads and hazard checks.
module dec_regfile_sb #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [XLEN-1:0]           in_ir,
    input  logic [$clog2(NREG)-1:0]   in_rs,
    input  logic [$clog2(NREG)-1:0]   in_rt,
    input  logic [$clog2(NREG)-1:0]   in_dst,
    input  logic                      in_dst_we,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [XLEN-1:0]           out_ir,
    output logic [XLEN-1:0]           out_rs_data,
    output logic [XLEN-1:0]           out_rt_data,
    output logic [$clog2(NREG)-1:0]   out_dst,
    output logic                      out_dst_we,
    input  logic                      wb_we,
    input  logic [$clog2(NREG)-1:0]   wb_addr,
    input  logic [XLEN-1:0]           wb_data,
    input  logic                      flush,
    output logic [NREG-1:0]           busy_vec,
    output logic [15:0]               stall_cnt
);
    localparam int unsigned AW = $clog2(NREG);

    logic [XLEN-1:0] r_rf [NREG];
    logic [NREG-1:0] r_busy;
    logic            r_out_valid;
    logic [XLEN-1:0] r_out_ir;
    logic [XLEN-1:0] r_out_rs_data;
    logic [XLEN-1:0] r_out_rt_data;
    logic [AW-1:0]   r_out_dst;
    logic            r_out_dst_we;
    logic [15:0]     r_stall_cnt;

    logic            w_wb_rs;
    logic            w_wb_rt;
    logic            w_wb_dst;
    logic [XLEN-1:0] w_rs_data;
    logic [XLEN-1:0] w_rt_data;
    logic            w_hz_rs;
    logic            w_hz_rt;
    logic            w_hz_d;
    logic            w_accept;
    logic [NREG-1:0] w_busy_nxt;

    // Writeback address matches, qualified so r0 never forwards
    assign w_wb_rs  = wb_we && (wb_addr == in_rs)  && (in_rs  != '0);
    assign w_wb_rt  = wb_we && (wb_addr == in_rt)  && (in_rt  != '0);
    assign w_wb_dst = wb_we && (wb_addr == in_dst) && (in_dst != '0);

`ifdef RF_BYPASS_EN
    always_comb begin
        w_rs_data = '0;
        w_rt_data = '0;
        if (w_wb_rs)
            w_rs_data = wb_data;
        else if (in_rs != '0)
            w_rs_data = r_rf[in_rs];
        if (w_wb_rt)
            w_rt_data = wb_data;
        else if (in_rt != '0)
            w_rt_data = r_rf[in_rt];
    end

    assign w_hz_rs = r_busy[in_rs] && (in_rs != '0) && !w_wb_rs;
    assign w_hz_rt = r_busy[in_rt] && (in_rt != '0) && !w_wb_rt;
    assign w_hz_d  = in_dst_we && (in_dst != '0) && r_busy[in_dst] && !w_wb_dst;
`else
    always_comb begin
        w_rs_data = '0;
        w_rt_data = '0;
        if (in_rs != '0)
            w_rs_data = r_rf[in_rs];
        if (in_rt != '0)
            w_rt_data = r_rf[in_rt];
    end

    // Busy bits alone gate issue; the waiter goes the cycle after writeback
    assign w_hz_rs = r_busy[in_rs] && (in_rs != '0) && !(w_wb_rs && 1'b0);
    assign w_hz_rt = r_busy[in_rt] && (in_rt != '0) && !(w_wb_rt && 1'b0);
    assign w_hz_d  = in_dst_we && (in_dst != '0) && r_busy[in_dst] && !(w_wb_dst && 1'b0);
`endif

    assign in_ready = !flush && !w_hz_rs && !w_hz_rt && !w_hz_d
                      && (!r_out_valid || out_ready);
    assign w_accept = in_valid && in_ready;

    // Scoreboard update: clears first, accept set last so it wins
    always_comb begin
        w_busy_nxt = r_busy;
        if (wb_we)
            w_busy_nxt[wb_addr] = 1'b0;
        if (flush && r_out_valid && r_out_dst_we)
            w_busy_nxt[r_out_dst] = 1'b0;
        if (w_accept && in_dst_we)
            w_busy_nxt[in_dst] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(NREG); i++)
                r_rf[i] <= '0;
        end else if (wb_we && (wb_addr != '0)) begin
            r_rf[wb_addr] <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_busy <= '0;
        else
            r_busy <= w_busy_nxt;
    end

    // Issue register: flush drops, accept loads, handoff empties
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_valid   <= 1'b0;
            r_out_ir      <= '0;
            r_out_rs_data <= '0;
            r_out_rt_data <= '0;
            r_out_dst     <= '0;
            r_out_dst_we  <= 1'b0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_valid   <= 1'b1;
            r_out_ir      <= in_ir;
            r_out_rs_data <= w_rs_data;
            r_out_rt_data <= w_rt_data;
            r_out_dst     <= in_dst;
            r_out_dst_we  <= in_dst_we;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_stall_cnt <= '0;
        else if (in_valid && !in_ready && !flush && (r_stall_cnt != 16'hFFFF))
            r_stall_cnt <= r_stall_cnt + 16'd1;
    end

    assign out_valid   = r_out_valid;
    assign out_ir      = r_out_ir;
    assign out_rs_data = r_out_rs_data;
    assign out_rt_data = r_out_rt_data;
    assign out_dst     = r_out_dst;
    assign out_dst_we  = r_out_dst_we;
    assign busy_vec    = r_busy;
    assign stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_dec_regfile_sb.sv
// Directed bench for dec_regfile_sb; expectations track the RF_BYPASS_EN setting.
module tb_dec_regfile_sb;
    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;
    localparam int unsigned AW   = 5;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_ir;
    logic [AW-1:0]   in_rs;
    logic [AW-1:0]   in_rt;
    logic [AW-1:0]   in_dst;
    logic            in_dst_we;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_ir;
    logic [XLEN-1:0] out_rs_data;
    logic [XLEN-1:0] out_rt_data;
    logic [AW-1:0]   out_dst;
    logic            out_dst_we;
    logic            wb_we;
    logic [AW-1:0]   wb_addr;
    logic [XLEN-1:0] wb_data;
    logic            flush;
    logic [NREG-1:0] busy_vec;
    logic [15:0]     stall_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_sc = 0;

    always #5 clk = ~clk;

    dec_regfile_sb #(.XLEN(XLEN), .NREG(NREG)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_ir(in_ir),
        .in_rs(in_rs), .in_rt(in_rt), .in_dst(in_dst), .in_dst_we(in_dst_we),
        .out_valid(out_valid), .out_ready(out_ready), .out_ir(out_ir),
        .out_rs_data(out_rs_data), .out_rt_data(out_rt_data),
        .out_dst(out_dst), .out_dst_we(out_dst_we),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .flush(flush), .busy_vec(busy_vec), .stall_cnt(stall_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] ir, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                         input logic [AW-1:0] dst, input logic we);
        in_valid  = 1'b1;
        in_ir     = ir;
        in_rs     = rs;
        in_rt     = rt;
        in_dst    = dst;
        in_dst_we = we;
    endtask

    initial begin
        reset = 1'b0;
        in_valid = 1'b0; in_ir = '0; in_rs = '0; in_rt = '0; in_dst = '0; in_dst_we = 1'b0;
        out_ready = 1'b0; wb_we = 1'b0; wb_addr = '0; wb_data = '0; flush = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", busy_vec, 32'd0);
        check("rst_stall", 32'(stall_cnt), 32'd0);
        tick(); tick();
        reset = 1'b1;

        // 1: write r5 then read it
        wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'h1234;
        tick();
        wb_we = 1'b0;
        issue(32'hAAAA0001, 5'd5, 5'd0, 5'd0, 1'b0);
        #1 check("t1_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("t1_valid", 32'(out_valid), 32'd1);
        check("t1_ir", out_ir, 32'hAAAA0001);
        check("t1_rs", out_rs_data, 32'h1234);
        check("t1_rt", out_rt_data, 32'd0);

        // 2: producer to r8, consumer stalls until writeback
        out_ready = 1'b1;
        issue(32'hAAAA0002, 5'd0, 5'd0, 5'd8, 1'b1);
        tick();
        check("t2_busy8", busy_vec, 32'h0000_0100);
        check("t2_dst", 32'(out_dst), 32'd8);
        issue(32'hAAAA0003, 5'd8, 5'd0, 5'd0, 1'b0);
        #1 check("t2_stall_ready", 32'(in_ready), 32'd0);
        tick();
        exp_sc = 1;
        check("t2_stall_cnt", 32'(stall_cnt), 32'(exp_sc));
        check("t2_drained", 32'(out_valid), 32'd0);
        wb_we = 1'b1; wb_addr = 5'd8; wb_data = 32'hABCD;
`ifdef RF_BYPASS_EN
        #1 check("t2_wb_ready", 32'(in_ready), 32'd1);
        tick();
        wb_we = 1'b0;
`else
        #1 check("t2_wb_ready", 32'(in_ready), 32'd0);
        tick();
        wb_we = 1'b0;
        exp_sc = 2;
        check("t2_busy_clr", busy_vec, 32'd0);
        check("t2_not_yet", 32'(out_valid), 32'd0);
        #1 check("t2_late_ready", 32'(in_ready), 32'd1);
        tick();
`endif
        in_valid = 1'b0;
        check("t2_valid", 32'(out_valid), 32'd1);
        check("t2_ir", out_ir, 32'hAAAA0003);
        check("t2_rs", out_rs_data, 32'hABCD);
        check("t2_busy_after", busy_vec, 32'd0);
        check("t2_stall_final", 32'(stall_cnt), 32'(exp_sc));

        // 3: back-pressure holds the issue register
        out_ready = 1'b0;
        issue(32'hAAAA0004, 5'd5, 5'd5, 5'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1 check("t3_ready", 32'(in_ready), 32'd0);
            tick();
            check("t3_hold_ir", out_ir, 32'hAAAA0003);
            check("t3_hold_rs", out_rs_data, 32'hABCD);
        end
        exp_sc = exp_sc + 3;
        check("t3_stall_cnt", 32'(stall_cnt), 32'(exp_sc));
        out_ready = 1'b1;
        #1 check("t3_release", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("t3_ir", out_ir, 32'hAAAA0004);
        check("t3_rs", out_rs_data, 32'h1234);
        check("t3_rt", out_rt_data, 32'h1234);

        // 4: flush drops held dst=3 and its busy bit
        issue(32'hAAAA0005, 5'd0, 5'd0, 5'd3, 1'b1);
        tick();
        in_valid = 1'b0;
        out_ready = 1'b0;
        tick();
        check("t4_busy3", busy_vec, 32'h0000_0008);
        check("t4_held", out_ir, 32'hAAAA0005);
        flush = 1'b1; out_ready = 1'b1;
        issue(32'hAAAA0006, 5'd0, 5'd0, 5'd0, 1'b0);
        #1 check("t4_flush_ready", 32'(in_ready), 32'd0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("t4_valid", 32'(out_valid), 32'd0);
        check("t4_busy", busy_vec, 32'd0);
        check("t4_stall_cnt", 32'(stall_cnt), 32'(exp_sc));

        // 5: same-edge clear and set of r4; writes to r0 ignored
        wb_we = 1'b1; wb_addr = 5'd4; wb_data = 32'h44;
        issue(32'hAAAA0008, 5'd0, 5'd0, 5'd4, 1'b1);
        tick();
        in_valid = 1'b0;
        check("t5_set_wins", busy_vec, 32'h0000_0010);
        wb_data = 32'h55;
        tick();
        check("t5_busy_clr", busy_vec, 32'd0);
        wb_addr = 5'd0; wb_data = 32'hDEAD;
        issue(32'hAAAA0009, 5'd0, 5'd4, 5'd0, 1'b1);
        tick();
        wb_we = 1'b0;
        check("t5_r0_fwd", out_rs_data, 32'd0);
        check("t5_rt", out_rt_data, 32'h55);
        check("t5_busy0", busy_vec, 32'd0);
        issue(32'hAAAA000A, 5'd0, 5'd0, 5'd7, 1'b1);
        tick();
        check("t5_r0_arr", out_rs_data, 32'd0);
        check("t6_busy7", busy_vec, 32'h0000_0080);

        // 6: long hazard saturates, then async reset mid-stall
        issue(32'hAAAA000B, 5'd7, 5'd0, 5'd0, 1'b0);
        repeat (70000) @(posedge clk);
        #1;
        check("t6_sat", 32'(stall_cnt), 32'h0000_FFFF);
        check("t6_ready", 32'(in_ready), 32'd0);
        #2 reset = 1'b0;
        #1;
        check("t6_rst_stall", 32'(stall_cnt), 32'd0);
        check("t6_rst_busy", busy_vec, 32'd0);
        check("t6_rst_valid", 32'(out_valid), 32'd0);
        in_valid = 1'b0;
        tick();
        reset = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/dec_regfile_sb.md
Name: dec_regfile_sb

Overview:
Parametrised decode-stage register file with a write-pending scoreboard and a D->E issue register.
- Sits between fetch/decode and execute in the pipeline.
- Reads two source operands and blocks issue on RAW/WAW hazards against in-flight producers.
- Holds the issued instruction in an output register with valid/ready handshake.
- Writeback from W clears pending bits; flush drops the held instruction.

Parameters:
XLEN, 32, data/instruction width in bits
NREG, 32, number of architectural registers; register 0 reads zero and is never written or marked busy
AW, $clog2(NREG), register index width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  decoded instruction presented
in_ready  out  1  instruction accepted this cycle when in_valid&in_ready
in_ir  in  XLEN  instruction word, passed through
in_rs  in  AW  source register 1 index
in_rt  in  AW  source register 2 index
in_dst  in  AW  destination register index
in_dst_we  in  1  instruction writes in_dst
out_valid  out  1  issue register holds an instruction
out_ready  in  1  execute stage takes the instruction
out_ir  out  XLEN  issued instruction word
out_rs_data  out  XLEN  operand 1 captured at issue
out_rt_data  out  XLEN  operand 2 captured at issue
out_dst  out  AW  issued destination index
out_dst_we  out  1  issued destination write enable
wb_we  in  1  writeback enable from W
wb_addr  in  AW  writeback index
wb_data  in  XLEN  writeback data
flush  in  1  drop the instruction in the issue register
busy_vec  out  NREG  scoreboard pending bits, bit 0 always 0
stall_cnt  out  16  saturating count of hazard-stall cycles

Behaviour:
Reset (reset=0, async): all registers and outputs are 0, including out_valid, busy_vec and stall_cnt.

Register file
- Register write on clk when wb_we & wb_addr!=0.
- Reads are combinational. Write-first bypass applies: when wb_we & wb_addr==idx & idx!=0, read data is wb_data.
- Index 0 always reads 0.

Hazard, per source s in {rs, rt}
- hz_s = busy[s] & s!=0 & !(wb_we & wb_addr==s).
- WAW: hz_d = in_dst_we & in_dst!=0 & busy[in_dst] & !(wb_we & wb_addr==in_dst).
- in_ready = !flush & !hz_rs & !hz_rt & !hz_d & (!out_valid | out_ready).

Issue (accept = in_valid & in_ready), on the same edge:
- out_* load from in_*, with operands taken from the bypassed reads.
- out_valid becomes 1.
- busy[in_dst] is set when in_dst_we & in_dst!=0.

Issue-register handshake
- out_valid & out_ready without accept: out_valid goes 0 next cycle.
- Otherwise out_* hold stable while out_valid & !out_ready.

Writeback
- wb_we clears busy[wb_addr].
- If the same edge sets the same bit via accept, set wins.

Flush
- out_valid becomes 0 and no accept occurs that cycle.
- If out_valid & out_dst_we, busy[out_dst] is cleared.
- Flush wins over a simultaneous out_ready handoff: the instruction is dropped.
- Instructions already handed to E are unaffected.

Stall counter
- Increments when in_valid & !in_ready & !flush.
- Saturates at 16'hFFFF.

Latency: 1 cycle from accept to out_valid.

Reset mid-operation: all in-flight state is discarded immediately. busy_vec goes to 0.

Optional Feature:
RF_BYPASS_EN
- Defined: write-first bypass in reads and the !(wb_we&wb_addr==s) terms in the hazard equations, as above.
- Undefined: reads return array contents only, and hazards use busy bits only. An instruction waiting on a register issues one cycle after its writeback (stall one extra cycle); writeback data is never forwarded.

Test Plan:
1. Reset release, write r5=32'h1234 via wb, then issue rs=5,rt=0 -> out_rs_data=32'h1234, out_rt_data=0, out_valid=1 one cycle later.
2. Issue dst=8 dst_we=1 -> busy_vec[8]=1. Next instr rs=8 stalls, in_ready=0, stall_cnt increments. wb r8=32'hABCD -> with RF_BYPASS_EN accepts same cycle with operand 32'hABCD; without it accepts the next cycle.
3. out_ready=0 for 3 cycles with new in_valid -> out_* unchanged, in_ready=0. out_ready=1 -> next instr loads the following cycle.
4. Issued dst=3 held in issue register, flush=1 with out_ready=1 -> out_valid=0, busy_vec[3]=0, in_valid instr not accepted that cycle.
5. Same-edge wb_addr=4 and accept of dst=4 -> busy_vec[4]=1 afterwards. Writes to r0 -> r0 reads 0, busy_vec[0]=0.
6. Hold a hazard 70000 cycles -> stall_cnt=16'hFFFF. Assert reset=0 mid-stall -> stall_cnt, busy_vec and out_valid all 0 asynchronously.
